// File: rtl/cpu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_ctrl
// Description : Control unit for the 4-stage pipelined 16-bit CPU
//               (fetch, decode, execute, rf writeback). Decodes the decode,
//               execute and writeback IRs. Drives every datapath load
//               enable, mux select and flush. Resolves writeback bypassing,
//               branch redirection and the cmp->branch flag hazard. Keeps
//               retired-instruction and taken-branch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_pipe_ctrl #(
    parameter int          CNT_W  = 32,
    parameter logic [15:0] NOP_IR = 16'h0007
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      i_ir_decode,
    input  logic [15:0]      i_ir_execute,
    input  logic [15:0]      i_ir_rf_write,
    input  logic             i_n,
    input  logic             i_z,
    output logic             o_pc_ld,
    output logic             o_decode_pc_ld,
    output logic             o_decode_ir_ld,
    output logic [1:0]       o_pc_addr_sel,
    output logic             o_flush_w,
    output logic             o_flush_f,
    output logic             o_fwd_pc,
    output logic             o_execute_pc_ld,
    output logic             o_execute_ir_ld,
    output logic             o_rf_rx_rd,
    output logic             o_rf_ry_rd,
    output logic             o_rx_d_sel,
    output logic             o_ry_d_sel,
    output logic             o_rfwrite_pc_ld,
    output logic             o_rfwrite_ir_ld,
    output logic             o_rfx_wr_ld,
    output logic             o_rfy_wr_ld,
    output logic             o_alu_a_sel,
    output logic [1:0]       o_alu_b_sel,
    output logic             o_alu_op,
    output logic             o_alu_ld_n,
    output logic             o_alu_ld_z,
    output logic             o_alu_A_ld,
    output logic             o_rfx_wr_sel,
    output logic             o_rfy_wr_sel,
    output logic             o_ldst_addr_sel,
    output logic             o_ldst_wrdata_sel,
    output logic             o_rf_wr,
    output logic             o_rf_seven,
    output logic [2:0]       o_rf_sel,
    output logic [CNT_W-1:0] o_retired,
    output logic [CNT_W-1:0] o_taken
);

    // Opcodes
    localparam logic [3:0] c_OP_MV   = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_CMP  = 4'd3;
    localparam logic [3:0] c_OP_LD   = 4'd4;
    localparam logic [3:0] c_OP_MVHI = 4'd6;
    localparam logic [3:0] c_OP_J    = 4'd8;
    localparam logic [3:0] c_OP_JZ   = 4'd9;
    localparam logic [3:0] c_OP_JN   = 4'd10;
    localparam logic [3:0] c_OP_CALL = 4'd12;

    // Regfile write-data source selects
    localparam logic [2:0] c_SEL_MV   = 3'd0;
    localparam logic [2:0] c_SEL_MVHI = 3'd1;
    localparam logic [2:0] c_SEL_ALU  = 3'd2;
    localparam logic [2:0] c_SEL_CALL = 3'd3;
    localparam logic [2:0] c_SEL_LD   = 3'd4;
    localparam logic [2:0] c_SEL_MVI  = 3'd5;

    // PC source selects
    localparam logic [1:0] c_PC_INC = 2'd0;
    localparam logic [1:0] c_PC_REG = 2'd1;
    localparam logic [1:0] c_PC_REL = 2'd2;

    // ALU operand B selects
    localparam logic [1:0] c_B_RY   = 2'd0;
    localparam logic [1:0] c_B_IMM  = 2'd1;
    localparam logic [1:0] c_B_BYP  = 2'd2;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_wb_bubble;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_taken;

    // Instruction fields per stage
    logic [3:0] w_dec_op;
    logic [2:0] w_dec_rx;
    logic [2:0] w_dec_ry;
    logic [3:0] w_ex_op;
    logic       w_ex_imm;
    logic [2:0] w_ex_rx;
    logic [2:0] w_ex_ry;
    logic [3:0] w_wb_op;
    logic       w_wb_imm;
    logic [2:0] w_wb_rx;

    logic       w_stage_run;
    logic       w_wb_valid;
    logic       w_wb_writes;
    logic [2:0] w_wb_rf_sel;
    logic [2:0] w_wb_target;
    logic       w_byp_valid;
    logic       w_fwd_x;
    logic       w_fwd_y;
    logic       w_ex_is_jump;
    logic       w_flag_hazard;
    logic       w_taken;
    logic       w_retire;
    logic       w_unused_bits;

    assign w_dec_op = i_ir_decode[3:0];
    assign w_dec_rx = i_ir_decode[7:5];
    assign w_dec_ry = i_ir_decode[10:8];
    assign w_ex_op  = i_ir_execute[3:0];
    assign w_ex_imm = i_ir_execute[4];
    assign w_ex_rx  = i_ir_execute[7:5];
    assign w_ex_ry  = i_ir_execute[10:8];
    assign w_wb_op  = i_ir_rf_write[3:0];
    assign w_wb_imm = i_ir_rf_write[4];
    assign w_wb_rx  = i_ir_rf_write[7:5];

    assign w_unused_bits = ^{i_ir_decode[15:11], i_ir_decode[4], i_ir_execute[15:11]};

    // Decode and execute act only while the pipeline is streaming; in STALL
    // the execute IR is held and is evaluated on the following RUN cycle.
    assign w_stage_run = !reset && ((r_state == S_FILL) || (r_state == S_RUN));

    // Writeback is live in every running state except the bubble cycle
    // that follows a stall.
    assign w_wb_valid  = !reset && (r_state != S_RST) && !r_wb_bubble;

    // The hazard is judged from the decode/execute pair; the hold itself is
    // applied in the STALL state on the next cycle.
    assign w_flag_hazard = ((w_dec_op == c_OP_JZ) || (w_dec_op == c_OP_JN)) &&
                           ((w_ex_op == c_OP_ADD) || (w_ex_op == c_OP_SUB) ||
                            (w_ex_op == c_OP_CMP));

    // State register and post-stall bubble marker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RST;
            r_wb_bubble <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_wb_bubble <= (r_state == S_STALL);
        end
    end

    // Next-state logic and pipeline register load enables
    always_comb begin
        w_next_state    = r_state;
        o_pc_ld         = 1'b0;
        o_decode_pc_ld  = 1'b0;
        o_decode_ir_ld  = 1'b0;
        o_execute_pc_ld = 1'b0;
        o_execute_ir_ld = 1'b0;
        o_rf_rx_rd      = 1'b0;
        o_rf_ry_rd      = 1'b0;
        o_rfwrite_pc_ld = 1'b0;
        o_rfwrite_ir_ld = 1'b0;
        o_rfx_wr_ld     = 1'b0;
        o_rfy_wr_ld     = 1'b0;
        o_flush_w       = 1'b0;
        if (reset) begin
            w_next_state = S_RST;
        end else begin
            case (r_state)
                S_RST: begin
                    o_pc_ld      = 1'b1;
                    w_next_state = S_FILL;
                end
                S_FILL, S_RUN: begin
                    o_pc_ld         = 1'b1;
                    o_decode_pc_ld  = 1'b1;
                    o_decode_ir_ld  = 1'b1;
                    o_execute_pc_ld = 1'b1;
                    o_execute_ir_ld = 1'b1;
                    o_rf_rx_rd      = 1'b1;
                    o_rf_ry_rd      = 1'b1;
                    o_rfwrite_pc_ld = 1'b1;
                    o_rfwrite_ir_ld = 1'b1;
                    o_rfx_wr_ld     = 1'b1;
                    o_rfy_wr_ld     = 1'b1;
                    if (r_state == S_FILL) begin
                        o_flush_w    = 1'b1;
                        w_next_state = S_RUN;
                    end else if (w_flag_hazard) begin
                        w_next_state = S_STALL;
                    end
                end
                S_STALL: begin
                    // Front stages hold; only the WB IR loads, taking the bubble.
                    o_rfwrite_ir_ld = 1'b1;
                    w_next_state    = S_RUN;
                end
                default: begin
                    w_next_state = S_RST;
                end
            endcase
        end
    end

    // Writeback decode: register-write class and write-data source
    always_comb begin
        w_wb_writes = 1'b0;
        w_wb_rf_sel = c_SEL_MV;
        case (w_wb_op)
            c_OP_MV: begin
                w_wb_writes = 1'b1;
                w_wb_rf_sel = w_wb_imm ? c_SEL_MVI : c_SEL_MV;
            end
            c_OP_MVHI: begin
                w_wb_writes = 1'b1;
                w_wb_rf_sel = c_SEL_MVHI;
            end
            c_OP_ADD, c_OP_SUB: begin
                w_wb_writes = 1'b1;
                w_wb_rf_sel = c_SEL_ALU;
            end
            c_OP_CALL: begin
                w_wb_writes = 1'b1;
                w_wb_rf_sel = c_SEL_CALL;
            end
            c_OP_LD: begin
                w_wb_writes = 1'b1;
                w_wb_rf_sel = c_SEL_LD;
            end
            default: begin
                w_wb_writes = 1'b0;
            end
        endcase
    end

    assign w_byp_valid = w_wb_valid && w_wb_writes;
    assign w_wb_target = (w_wb_op == c_OP_CALL) ? 3'd7 : w_wb_rx;
    assign o_rf_wr     = w_byp_valid;
    assign o_rf_seven  = w_byp_valid && (w_wb_op == c_OP_CALL);
    assign o_rf_sel    = w_wb_valid ? w_wb_rf_sel : c_SEL_MV;
    assign w_retire    = w_wb_valid && (i_ir_rf_write != NOP_IR);

    assign w_fwd_x      = w_byp_valid && (w_ex_rx == w_wb_target);
    assign w_fwd_y      = w_byp_valid && (w_ex_ry == w_wb_target);
    assign w_ex_is_jump = (w_ex_op == c_OP_J)  || (w_ex_op == c_OP_JZ) ||
                          (w_ex_op == c_OP_JN) || (w_ex_op == c_OP_CALL);

    // Decode/execute bypass selects, ALU control and branch resolution
    always_comb begin
        o_rx_d_sel        = 1'b0;
        o_ry_d_sel        = 1'b0;
        o_alu_a_sel       = 1'b0;
        o_alu_b_sel       = c_B_RY;
        o_rfx_wr_sel      = 1'b0;
        o_rfy_wr_sel      = 1'b0;
        o_ldst_addr_sel   = 1'b0;
        o_ldst_wrdata_sel = 1'b0;
        o_fwd_pc          = 1'b0;
        o_alu_op          = 1'b0;
        o_alu_ld_n        = 1'b0;
        o_alu_ld_z        = 1'b0;
        o_alu_A_ld        = 1'b0;
        o_pc_addr_sel     = c_PC_INC;
        o_flush_f         = 1'b0;
        w_taken           = 1'b0;
        if (w_stage_run) begin
            o_rx_d_sel        = w_byp_valid && (w_dec_rx == w_wb_target);
            o_ry_d_sel        = w_byp_valid && (w_dec_ry == w_wb_target);
            o_alu_a_sel       = w_fwd_x;
            // An immediate operand always wins over the bypass path.
            o_alu_b_sel       = w_ex_imm ? c_B_IMM : (w_fwd_y ? c_B_BYP : c_B_RY);
            o_rfx_wr_sel      = w_fwd_x;
            o_rfy_wr_sel      = w_fwd_y;
            o_ldst_addr_sel   = w_fwd_y;
            o_ldst_wrdata_sel = w_fwd_x;
            o_fwd_pc          = w_ex_is_jump && !w_ex_imm && w_fwd_x;
            case (w_ex_op)
                c_OP_ADD: begin
                    o_alu_ld_n = 1'b1;
                    o_alu_ld_z = 1'b1;
                    o_alu_A_ld = 1'b1;
                end
                c_OP_SUB: begin
                    o_alu_op   = 1'b1;
                    o_alu_ld_n = 1'b1;
                    o_alu_ld_z = 1'b1;
                    o_alu_A_ld = 1'b1;
                end
                c_OP_CMP: begin
                    o_alu_op   = 1'b1;
                    o_alu_ld_n = 1'b1;
                    o_alu_ld_z = 1'b1;
                end
                c_OP_J, c_OP_CALL: begin
                    w_taken = 1'b1;
                end
                c_OP_JZ: begin
                    w_taken = i_z;
                end
                c_OP_JN: begin
                    w_taken = i_n;
                end
                default: begin
                    w_taken = 1'b0;
                end
            endcase
            if (w_taken) begin
                o_flush_f     = 1'b1;
                o_pc_addr_sel = w_ex_imm ? c_PC_REL : c_PC_REG;
            end
        end
    end

    // Performance counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_taken   <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_taken) begin
                r_taken <= r_taken + CNT_W'(1);
            end
        end
    end

    assign o_retired = r_retired;
    assign o_taken   = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_cpu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_pipe_ctrl
// Description : Self-checking bench for cpu_pipe_ctrl. Directed scenarios
//               followed by randomized IR/flag/reset stimulus, every cycle
//               compared against a table-driven reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pipe_ctrl;

    // Narrow counters so that wrap-around is reached within the run.
    localparam int          CNT_W   = 4;
    localparam int          CNT_MOD = 1 << CNT_W;
    localparam logic [15:0] NOP_IR  = 16'h0007;

    localparam int PH_BOOT = 0;
    localparam int PH_FILL = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_HOLD = 3;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] ir_d, ir_e, ir_w;
    logic n_in, z_in;

    logic o_pc_ld, o_decode_pc_ld, o_decode_ir_ld, o_flush_w, o_flush_f, o_fwd_pc;
    logic [1:0] o_pc_addr_sel, o_alu_b_sel;
    logic o_execute_pc_ld, o_execute_ir_ld, o_rf_rx_rd, o_rf_ry_rd, o_rx_d_sel, o_ry_d_sel;
    logic o_rfwrite_pc_ld, o_rfwrite_ir_ld, o_rfx_wr_ld, o_rfy_wr_ld, o_alu_a_sel, o_alu_op;
    logic o_alu_ld_n, o_alu_ld_z, o_alu_A_ld, o_rfx_wr_sel, o_rfy_wr_sel;
    logic o_ldst_addr_sel, o_ldst_wrdata_sel, o_rf_wr, o_rf_seven;
    logic [2:0] o_rf_sel;
    logic [CNT_W-1:0] o_retired, o_taken;

    cpu_pipe_ctrl #(.CNT_W(CNT_W), .NOP_IR(NOP_IR)) u_dut (
        .clk(clk), .reset(reset),
        .i_ir_decode(ir_d), .i_ir_execute(ir_e), .i_ir_rf_write(ir_w),
        .i_n(n_in), .i_z(z_in),
        .o_pc_ld(o_pc_ld), .o_decode_pc_ld(o_decode_pc_ld), .o_decode_ir_ld(o_decode_ir_ld),
        .o_pc_addr_sel(o_pc_addr_sel), .o_flush_w(o_flush_w), .o_flush_f(o_flush_f),
        .o_fwd_pc(o_fwd_pc), .o_execute_pc_ld(o_execute_pc_ld), .o_execute_ir_ld(o_execute_ir_ld),
        .o_rf_rx_rd(o_rf_rx_rd), .o_rf_ry_rd(o_rf_ry_rd), .o_rx_d_sel(o_rx_d_sel),
        .o_ry_d_sel(o_ry_d_sel), .o_rfwrite_pc_ld(o_rfwrite_pc_ld),
        .o_rfwrite_ir_ld(o_rfwrite_ir_ld), .o_rfx_wr_ld(o_rfx_wr_ld), .o_rfy_wr_ld(o_rfy_wr_ld),
        .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_alu_op(o_alu_op),
        .o_alu_ld_n(o_alu_ld_n), .o_alu_ld_z(o_alu_ld_z), .o_alu_A_ld(o_alu_A_ld),
        .o_rfx_wr_sel(o_rfx_wr_sel), .o_rfy_wr_sel(o_rfy_wr_sel),
        .o_ldst_addr_sel(o_ldst_addr_sel), .o_ldst_wrdata_sel(o_ldst_wrdata_sel),
        .o_rf_wr(o_rf_wr), .o_rf_seven(o_rf_seven), .o_rf_sel(o_rf_sel),
        .o_retired(o_retired), .o_taken(o_taken)
    );

    always #5 clk = ~clk;

    // ISA tables: which opcodes write the regfile and their write-data source.
    bit wr_tab    [16] = '{1,1,1,0,1,0,1,0,0,0,0,0,1,0,0,0};
    int rfsel_tab [16] = '{0,2,2,0,4,0,1,0,0,0,0,0,3,0,0,0};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_phase = PH_BOOT;
    bit m_after_hold = 1'b0;
    int m_ret = 0;
    int m_tkn = 0;

    // Snapshots of the most recent sample for directed checks
    logic [10:0] s_loads;
    logic        s_flush_w, s_flush_f, s_alu_a_sel, s_rf_seven, s_fwd_pc;
    logic [1:0]  s_pc_addr_sel, s_alu_b_sel;
    logic [2:0]  s_rf_sel;
    logic [CNT_W-1:0] s_retired, s_taken;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_ir(input int op, input int imm, input int rx, input int ry);
        mk_ir = {5'b0, 3'(ry), 3'(rx), 1'(imm), 4'(op)};
    endfunction

    // One clock: drive, predict, compare, advance the model past the edge.
    task automatic cycle(input logic r, input logic [15:0] d, input logic [15:0] e,
                         input logic [15:0] w, input logic nn, input logic zz);
        logic [3:0] dop, eop, wop;
        logic [10:0] e_loads;
        logic e_flush_w;
        logic [9:0] e_byp;
        logic [3:0] e_alu;
        logic [2:0] e_br;
        logic [4:0] e_wb;
        logic wb_live, wr, hx, hy, take, ejump;
        logic [2:0] dst;
        logic [1:0] bsel;
        int nxt;
        reset = r; ir_d = d; ir_e = e; ir_w = w; n_in = nn; z_in = zz;
        #2;
        dop = d[3:0]; eop = e[3:0]; wop = w[3:0];
        e_loads = '0; e_flush_w = 1'b0; e_byp = '0; e_alu = '0; e_br = '0; e_wb = '0;
        wb_live = 1'b0; wr = 1'b0; hx = 1'b0; hy = 1'b0; take = 1'b0; ejump = 1'b0;
        dst = 3'd0; bsel = 2'd0; nxt = m_phase;
        if (!r) begin
            case (m_phase)
                PH_BOOT: begin e_loads = 11'h400; nxt = PH_FILL; end
                PH_FILL: begin e_loads = 11'h7FF; e_flush_w = 1'b1; nxt = PH_RUN; end
                PH_RUN: begin
                    e_loads = 11'h7FF;
                    if ((dop == 9 || dop == 10) && eop >= 1 && eop <= 3) nxt = PH_HOLD;
                end
                default: begin e_loads = 11'h004; nxt = PH_RUN; end
            endcase
            wb_live = (m_phase != PH_BOOT) && !m_after_hold;
            wr  = wb_live && wr_tab[wop];
            dst = (wop == 12) ? 3'd7 : w[7:5];
            if (wb_live)
                e_wb = {wr, (wop == 4'd12), (wop == 0 && w[4]) ? 3'd5 : 3'(rfsel_tab[wop])};
            if (m_phase == PH_FILL || m_phase == PH_RUN) begin
                hx    = wr && (e[7:5] == dst);
                hy    = wr && (e[10:8] == dst);
                bsel  = e[4] ? 2'd1 : (hy ? 2'd2 : 2'd0);
                ejump = (eop == 8) || (eop == 9) || (eop == 10) || (eop == 12);
                e_byp = {wr && (d[7:5] == dst), wr && (d[10:8] == dst), hx, bsel,
                         hx, hy, hy, hx, ejump && !e[4] && hx};
                e_alu = {(eop == 2) || (eop == 3), (eop >= 1) && (eop <= 3),
                         (eop >= 1) && (eop <= 3), (eop == 1) || (eop == 2)};
                take  = (eop == 8) || (eop == 12) || (eop == 9 && zz) || (eop == 10 && nn);
                e_br  = {take ? (e[4] ? 2'd2 : 2'd1) : 2'd0, take};
            end
        end
        s_loads = {o_pc_ld, o_decode_pc_ld, o_decode_ir_ld, o_execute_pc_ld, o_execute_ir_ld,
                   o_rf_rx_rd, o_rf_ry_rd, o_rfwrite_pc_ld, o_rfwrite_ir_ld, o_rfx_wr_ld,
                   o_rfy_wr_ld};
        s_flush_w = o_flush_w; s_flush_f = o_flush_f; s_alu_a_sel = o_alu_a_sel;
        s_rf_seven = o_rf_seven; s_fwd_pc = o_fwd_pc; s_pc_addr_sel = o_pc_addr_sel;
        s_alu_b_sel = o_alu_b_sel; s_rf_sel = o_rf_sel; s_retired = o_retired; s_taken = o_taken;
        check_val("loads", s_loads, e_loads);
        check_val("flush_w", o_flush_w, e_flush_w);
        check_val("bypass", {o_rx_d_sel, o_ry_d_sel, o_alu_a_sel, o_alu_b_sel, o_rfx_wr_sel,
                             o_rfy_wr_sel, o_ldst_addr_sel, o_ldst_wrdata_sel, o_fwd_pc}, e_byp);
        check_val("alu", {o_alu_op, o_alu_ld_n, o_alu_ld_z, o_alu_A_ld}, e_alu);
        check_val("branch", {o_pc_addr_sel, o_flush_f}, e_br);
        check_val("wb", {o_rf_wr, o_rf_seven, o_rf_sel}, e_wb);
        check_val("retired", o_retired, 64'(m_ret));
        check_val("taken", o_taken, 64'(m_tkn));
        @(posedge clk);
        if (r) begin
            m_phase = PH_BOOT; m_ret = 0; m_tkn = 0; m_after_hold = 1'b0;
        end else begin
            if (wb_live && w != NOP_IR) m_ret = (m_ret + 1) % CNT_MOD;
            if (take) m_tkn = (m_tkn + 1) % CNT_MOD;
            m_after_hold = (m_phase == PH_HOLD);
            m_phase = nxt;
        end
        #1;
    endtask

    function automatic int rnd_reg();
        rnd_reg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
    endfunction

    function automatic logic [15:0] rnd_ir(input int bias_lo, input int bias_hi);
        int op;
        if ($urandom_range(0, 4) == 0) return NOP_IR;
        op = ($urandom_range(0, 2) == 0) ? int'($urandom_range(bias_lo, bias_hi))
                                         : int'($urandom_range(0, 15));
        rnd_ir = mk_ir(op, int'($urandom_range(0, 1)), rnd_reg(), rnd_reg());
    endfunction

    initial begin
        logic [15:0] nop;
        nop = NOP_IR;
        reset = 1'b1; ir_d = nop; ir_e = nop; ir_w = nop; n_in = 1'b0; z_in = 1'b0;
        @(posedge clk); #1;

        // Reset for two cycles, then RST -> FILL -> RUN
        cycle(1'b1, nop, nop, nop, 1'b0, 1'b0);
        cycle(1'b1, nop, nop, nop, 1'b0, 1'b0);
        check_val("t1_reset_loads", s_loads, 11'h000);
        cycle(1'b0, nop, nop, nop, 1'b0, 1'b0);
        check_val("t1_rst_loads", s_loads, 11'h400);
        check_val("t1_rst_retired", s_retired, 0);
        cycle(1'b0, nop, nop, nop, 1'b0, 1'b0);
        check_val("t1_fill_flush_w", s_flush_w, 1);
        check_val("t1_fill_loads", s_loads, 11'h7FF);
        cycle(1'b0, nop, nop, nop, 1'b0, 1'b0);
        check_val("t1_run_flush_w", s_flush_w, 0);
        check_val("t1_run_pcsel", s_pc_addr_sel, 0);
        check_val("t1_run_taken", s_taken, 0);

        // add r1,r2 in WB; add r3,r1 in execute
        cycle(1'b0, nop, mk_ir(1, 0, 3, 1), mk_ir(1, 0, 1, 2), 1'b0, 1'b0);
        check_val("t2_alu_a_sel", s_alu_a_sel, 0);
        check_val("t2_alu_b_sel", s_alu_b_sel, 2);

        // cmp r1,r1 in execute with jz +4 in decode: one stall, then taken
        cycle(1'b0, mk_ir(9, 1, 2, 0), mk_ir(3, 0, 1, 1), nop, 1'b0, 1'b0);
        cycle(1'b0, nop, mk_ir(9, 1, 2, 0), mk_ir(3, 0, 1, 1), 1'b0, 1'b1);
        check_val("t3_stall_loads", s_loads, 11'h004);
        check_val("t3_stall_pcsel", s_pc_addr_sel, 0);
        cycle(1'b0, nop, mk_ir(9, 1, 2, 0), nop, 1'b0, 1'b1);
        check_val("t3_jz_pcsel", s_pc_addr_sel, 2);
        check_val("t3_jz_flush_f", s_flush_f, 1);
        cycle(1'b0, nop, nop, nop, 1'b0, 1'b0);
        check_val("t3_taken", s_taken, 1);

        // jn with n=0: not taken
        cycle(1'b0, nop, mk_ir(10, 1, 2, 0), nop, 1'b0, 1'b1);
        check_val("t4_jn_pcsel", s_pc_addr_sel, 0);
        check_val("t4_jn_flush_f", s_flush_f, 0);
        cycle(1'b0, nop, nop, nop, 1'b0, 1'b0);
        check_val("t4_taken", s_taken, 1);

        // call in WB, jr r7 in execute
        cycle(1'b0, nop, mk_ir(8, 0, 7, 0), mk_ir(12, 1, 0, 0), 1'b0, 1'b0);
        check_val("t5_rf_seven", s_rf_seven, 1);
        check_val("t5_rf_sel", s_rf_sel, 3);
        check_val("t5_fwd_pc", s_fwd_pc, 1);
        check_val("t5_jr_pcsel", s_pc_addr_sel, 1);

        // reset asserted while in STALL
        cycle(1'b0, mk_ir(10, 1, 0, 0), mk_ir(2, 0, 1, 2), nop, 1'b0, 1'b0);
        cycle(1'b1, nop, mk_ir(10, 1, 0, 0), mk_ir(2, 0, 1, 2), 1'b0, 1'b0);
        check_val("t6_stall_reset_loads", s_loads, 11'h000);
        cycle(1'b1, nop, nop, nop, 1'b0, 1'b0);
        check_val("t6_rst_loads", s_loads, 11'h000);
        check_val("t6_rst_retired", s_retired, 0);
        check_val("t6_rst_taken", s_taken, 0);
        cycle(1'b0, nop, nop, nop, 1'b0, 1'b0);
        check_val("t6_release_loads", s_loads, 11'h400);

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  rnd_ir(9, 10), rnd_ir(1, 3), rnd_ir(0, 12),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
